// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: validates and issues one data-memory access at a time over a
// req/valid handshake, then aligns and extends returned load data for writeback.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Load,
  input  logic        Store,
  input  logic [2:0]  fun3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        valid,
  output logic        load_control,
  output logic        stall,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WB} state_t;

  state_t      r_state;
  logic [2:0]  r_fun3;
  logic [1:0]  r_lo;
  logic [7:0]  r_count;

  logic        w_go;
  logic        w_fun3_ok;
  logic        w_align_ok;
  logic        w_accept;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // Store takes priority, so its stricter fun3 legality applies when both are high.
  assign w_go      = Load | Store;
  assign w_fun3_ok = Store ? (fun3 < 3'b011) : (fun3[1:0] != 2'b11);

  always_comb begin
    w_align_ok = 1'b1;
    w_wmask    = 4'b1111;
    w_wdata    = store_data;
    case (fun3[1:0])
      2'b00: begin
        w_wmask = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_align_ok = ~addr[0];
        w_wmask    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{store_data[15:0]}};
      end
      default: w_align_ok = (addr[1:0] == 2'b00);
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && w_go && w_fun3_ok && w_align_ok;
  assign stall    = rst_n && ((r_state != S_IDLE) || w_accept);

  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (r_lo)
      2'b01:   w_byte = dmem_rdata[15:8];
      2'b10:   w_byte = dmem_rdata[23:16];
      2'b11:   w_byte = dmem_rdata[31:24];
      default: w_byte = dmem_rdata[7:0];
    endcase
    w_half = r_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_fun3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'h0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_fun3       <= 3'b000;
      r_lo         <= 2'b00;
      r_count      <= 8'h00;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'h0;
      dmem_wdata   <= 32'h0;
      dmem_wmask   <= 4'b0000;
      load_data    <= 32'h0;
      valid        <= 1'b0;
      load_control <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      load_control <= 1'b0;
      bus_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            dmem_req   <= 1'b1;
            dmem_we    <= Store;
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_wdata <= w_wdata;
            dmem_wmask <= Store ? w_wmask : 4'b0000;
            r_fun3     <= fun3;
            r_lo       <= addr[1:0];
            r_count    <= 8'h00;
            valid      <= 1'b1;
            r_state    <= S_WAIT;
          end else if (w_go) begin
            bus_err <= 1'b1;
          end
        end
        S_WAIT: begin
          if (dmem_valid) begin
            dmem_req <= 1'b0;
            if (!dmem_we) begin
              load_data    <= w_ext;
              load_control <= 1'b1;
              r_state      <= S_WB;
            end else begin
              valid   <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (r_count == 8'(TIMEOUT - 1)) begin
            // The access has held req for TIMEOUT cycles with no response.
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
            valid    <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        S_WB: begin
          valid   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: transaction-level model drives expected per-cycle outputs,
// a negedge checker compares them, plus directed literal checks and random traffic.
module tb_lsu_mem_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Load = 1'b0;
  logic        Store = 1'b0;
  logic [2:0]  fun3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        dmem_valid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_req, dmem_we, valid, load_control, stall, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic [3:0]  dmem_wmask;

  lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .Load(Load), .Store(Store), .fun3(fun3),
    .addr(addr), .store_data(store_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_valid(dmem_valid), .dmem_rdata(dmem_rdata), .load_data(load_data),
    .valid(valid), .load_control(load_control), .stall(stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic        exp_req, exp_valid, exp_stall, exp_lc, exp_berr, exp_we;
  logic [31:0] exp_addr, exp_wdata, model_ld;
  logic [3:0]  exp_wmask;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_wmask;
  logic        seen_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dmem_req", 32'(dmem_req), 32'(exp_req));
      chk("valid", 32'(valid), 32'(exp_valid));
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("load_control", 32'(load_control), 32'(exp_lc));
      chk("bus_err", 32'(bus_err), 32'(exp_berr));
      chk("load_data", load_data, model_ld);
      if (exp_req) begin
        chk("dmem_we", 32'(dmem_we), 32'(exp_we));
        chk("dmem_addr", dmem_addr, exp_addr);
        chk("dmem_wmask", 32'(dmem_wmask), 32'(exp_wmask));
        if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
        seen_addr  <= dmem_addr;
        seen_wdata <= dmem_wdata;
        seen_wmask <= dmem_wmask;
        seen_we    <= dmem_we;
      end
    end
  end

  function automatic int size_of(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit legal(input bit st, input logic [2:0] f, input logic [31:0] a);
    int sz;
    sz = size_of(f);
    if (f[1:0] == 2'b11) return 1'b0;
    if (st && f[2]) return 1'b0;
    if (sz == 2) return !a[0];
    if (sz == 4) return a[1:0] == 2'b00;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [2:0] f);
    int sz;
    logic [31:0] v;
    sz = size_of(f);
    if (sz == 4) return rd;
    v = rd >> (8 * a[1:0]);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f[2] && v[7]) v = v | 32'hFFFFFF00;
    end else begin
      v = v & 32'hFFFF;
      if (!f[2] && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_mask(input logic [31:0] a, input logic [2:0] f);
    int sz;
    sz = size_of(f);
    return 4'(((1 << sz) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [2:0] f);
    int sz;
    sz = size_of(f);
    if (sz == 1) return 32'(d[7:0]) * 32'h01010101;
    if (sz == 2) return 32'(d[15:0]) * 32'h00010001;
    return d;
  endfunction

  task automatic set_idle();
    exp_req = 1'b0; exp_valid = 1'b0; exp_stall = 1'b0; exp_lc = 1'b0; exp_berr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lat = req cycle carrying dmem_valid; lat > TO means the memory never answers.
  task automatic do_txn(input bit ld, input bit st, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input int lat);
    bit ok;
    int n;
    ok = legal(st, f, a);
    $display("txn ld=%0b st=%0b f3=%03b addr=%h data=%h rdata=%h lat=%0d legal=%0b",
             ld, st, f, a, d, rd, lat, ok);
    Load = ld; Store = st; fun3 = f; addr = a; store_data = d; dmem_valid = 1'b0;
    set_idle();
    exp_stall = ok;
    step();
    Load = 1'b0; Store = 1'b0;
    if (!ok) begin
      set_idle();
      exp_berr = 1'b1;
      step();
      return;
    end
    exp_we    = st;
    exp_addr  = {a[31:2], 2'b00};
    exp_wdata = ref_wdata(d, f);
    exp_wmask = st ? ref_mask(a, f) : 4'b0000;
    n = (lat < TO) ? lat : TO;
    for (int i = 1; i <= n; i++) begin
      Load = 1'($urandom); Store = 1'($urandom);
      fun3 = 3'($urandom); addr = $urandom;
      dmem_valid = (i == lat);
      dmem_rdata = (i == lat) ? rd : $urandom;
      exp_req = 1'b1; exp_valid = 1'b1; exp_stall = 1'b1; exp_lc = 1'b0; exp_berr = 1'b0;
      step();
    end
    dmem_valid = 1'b0; Load = 1'b0; Store = 1'b0;
    if (lat <= TO) begin
      if (!st) begin
        exp_req = 1'b0; exp_valid = 1'b1; exp_stall = 1'b1; exp_lc = 1'b1; exp_berr = 1'b0;
        model_ld = ref_load(rd, a, f);
        Load = 1'($urandom); Store = 1'($urandom);
        step();
        Load = 1'b0; Store = 1'b0;
      end
    end else begin
      set_idle();
      exp_berr = 1'b1;
      step();
    end
  endtask

  initial begin
    bit ld, st;
    int k, lat;
    logic [2:0] f;
    logic [31:0] a;

    set_idle();
    model_ld = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_we", 32'(dmem_we), 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_wmask", 32'(dmem_wmask), 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_lc", 32'(load_control), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_berr", 32'(bus_err), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    do_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 4);
    chk("lw_literal", load_data, 32'hDEADBEEF);
    do_txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1);
    chk("lb_literal", load_data, 32'hFFFFFF80);
    do_txn(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 2);
    chk("lbu_literal", load_data, 32'h00000080);
    do_txn(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 1);
    chk("lh_literal", load_data, 32'hFFFF80FF);
    do_txn(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 2);
    chk("sb_addr_literal", seen_addr, 32'h200);
    chk("sb_mask_literal", 32'(seen_wmask), 32'h2);
    chk("sb_wdata_literal", seen_wdata, 32'hABABABAB);
    chk("sb_we_literal", 32'(seen_we), 32'h1);
    do_txn(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1);
    do_txn(1'b0, 1'b1, 3'b001, 32'h301, 32'h1234, 32'h0, 1);
    do_txn(1'b1, 1'b0, 3'b010, 32'h140, 32'h0, 32'h12345678, TO + 1);
    do_txn(1'b1, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 1);
    chk("both_we_literal", 32'(seen_we), 32'h1);

    // Reset pulled while a load is waiting on memory.
    $display("txn mid-access reset during lw addr=00000500");
    Load = 1'b1; Store = 1'b0; fun3 = 3'b010; addr = 32'h500;
    set_idle();
    exp_stall = 1'b1;
    step();
    Load = 1'b0;
    chk_en = 1'b0;
    chk("mid_req_before", 32'(dmem_req), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 32'h0);
    chk("mid_rst_valid", 32'(valid), 32'h0);
    chk("mid_rst_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_ld = 32'h0;
    set_idle();
    chk_en = 1'b1;
    do_txn(1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 32'h0BADF00D, 1);
    chk("post_rst_lw", load_data, 32'h0BADF00D);

    for (int t = 0; t < 200; t++) begin
      k  = int'($urandom_range(0, 9));
      ld = (k < 5) || (k == 9);
      st = (k >= 5);
      f  = 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f[1:0] == 2'b10) a[1:0] = 2'b00;
        else if (f[1:0] == 2'b01) a[0] = 1'b0;
      end
      lat = int'($urandom_range(1, TO + 1));
      do_txn(ld, st, f, a, $urandom, $urandom, lat);
    end

    set_idle();
    Load = 1'b0; Store = 1'b0;
    step();
    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
